// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: byte width, arbiter state encoding.
package uart_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req_i starting at ptr_i,
// wrapping at NUM_REQ. Reusable by any shared-resource arbiter.
module rr_pick #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic               found_o
);
    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        onehot_o = '0;
        found_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr + k stays below 2*NUM_REQ, so one subtraction is enough to wrap
            sum = {1'b0, ptr_i} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found_o && req_i[idx]) begin
                onehot_o[idx] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx serializer between
// NUM_REQ byte-stream requesters; MAX_BURST caps bytes per grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [BYTE_W-1:0]              tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [7:0]       burst_q, burst_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner;
    logic [NUM_REQ-1:0] pick_onehot;
    logic             pick_found;
    logic             xfer, rel;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .found_o  (pick_found)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner = PTR_W'(i);
        end
    end

    // Owner is wired straight through so the first byte moves the cycle after the grant
    always_comb begin
        req_ready = '0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        if (state_q == ARB_LOCKED) begin
            tx_data          = req_data[owner];
            tx_valid         = req_valid[owner];
            req_ready[owner] = tx_ready;
        end
    end

    assign xfer     = (state_q == ARB_LOCKED) && req_valid[owner] && tx_ready;
    assign burst_d  = burst_q + 8'd1;
    // last on the MAX_BURST-th byte collapses into this single release
    assign rel      = xfer && (req_last[owner] || burst_d == 8'(MAX_BURST));
    assign rr_ptr_d = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            burst_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_onehot;
                        burst_q <= '0;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer) burst_q <= burst_d;
                    if (rel) begin
                        state_q  <= ARB_IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_LOCKED);

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_valid_locked: assert property (@(posedge clk) disable iff (rst) tx_valid |-> state_q == ARB_LOCKED);
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
endmodule
